// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl : pipeline sequencer for the 5-stage RV32 core.
//
// Decides every cycle whether each pipeline register advances, holds, bubbles
// or flushes. It handles load-use hazards in ID, mispredict redirects from EX
// and multi-cycle data-memory waits in MEM. It also holds the memory-wait FSM
// and its timeout supervisor.
//
// Ports
//   clk, reset           core clock, synchronous active-high reset
//   id_rs1/id_rs2        source register indices of the ID instruction
//   id_use_rs1/rs2       ID instruction actually reads that source
//   ex_rd, ex_is_load    destination / load flag of the EX instruction
//   branch_taken         EX mispredict, fetch redirects to branch_addr
//   dmem_req, dmem_ready MEM-stage access active / completing this cycle
//   stall                fetch advance enable (1 = PC updates)
//   ifid_hold/flush      IF/ID keep contents / load NOP
//   idex_hold/flush      ID/EX keep contents / load NOP (bubble)
//   exmem_hold           EX/MEM keep contents
//   memwb_flush          MEM/WB load NOP
//   bus_err              sticky memory-timeout flag
//   state_o              FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR
//
// Optional feature macro: HAZARD_PERF_EN
//   When defined, adds saturating 32-bit counters perf_lu_cnt,
//   perf_flush_cnt and perf_wait_cnt (load-use bubbles, mispredict flushes,
//   freeze cycles).
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_hold,
    output logic        idex_flush,
    output logic        exmem_hold,
    output logic        memwb_flush,
    output logic        bus_err,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_wait_cnt,
`endif
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_bus_err;

    logic w_lu;
    logic w_freeze;
    logic w_mp;
    logic w_lu_act;

    // x0 is never a real dependency, so a load to x0 never stalls.
    assign w_lu = ex_is_load && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

    // Freeze: ERR always; RUN on a wait-state access; MEM_WAIT until ready.
    // The ready cycle in MEM_WAIT falls through to the normal RUN rules.
    assign w_freeze = (r_state == ERR) ||
                      ((r_state == RUN) && dmem_req && !dmem_ready) ||
                      ((r_state == MEM_WAIT) && !dmem_ready);

    // EX is frozen during a freeze, so a masked branch_taken re-presents
    // on release and is not lost.
    assign w_mp     = !w_freeze && branch_taken;
    assign w_lu_act = !w_freeze && !branch_taken && w_lu;

    always_comb begin
        stall       = 1'b1;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_hold   = 1'b0;
        idex_flush  = 1'b0;
        exmem_hold  = 1'b0;
        memwb_flush = 1'b0;
        if (!reset) begin
            if (w_freeze) begin
                stall       = 1'b0;
                ifid_hold   = 1'b1;
                idex_hold   = 1'b1;
                exmem_hold  = 1'b1;
                memwb_flush = 1'b1;
            end else if (w_mp) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
            end else if (w_lu_act) begin
                stall       = 1'b0;
                ifid_hold   = 1'b1;
                idex_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        if (r_wait_cnt == CNT_W'(WAIT_TIMEOUT)) begin
                            r_state   <= ERR;
                            r_bus_err <= 1'b1;
                        end
                    end
                end
                ERR:     r_state <= ERR;   // only reset leaves ERR
                default: r_state <= RUN;
            endcase
        end
    end

    assign bus_err = r_bus_err;
    assign state_o = r_state;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_wait;

    // Counters saturate rather than wrap so a long run never reads low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_lu    <= '0;
            r_perf_flush <= '0;
            r_perf_wait  <= '0;
        end else begin
            if (w_lu_act && (r_perf_lu != 32'hFFFF_FFFF))
                r_perf_lu <= r_perf_lu + 32'd1;
            if (w_mp && (r_perf_flush != 32'hFFFF_FFFF))
                r_perf_flush <= r_perf_flush + 32'd1;
            if (w_freeze && (r_perf_wait != 32'hFFFF_FFFF))
                r_perf_wait <= r_perf_wait + 32'd1;
        end
    end

    assign perf_lu_cnt    = r_perf_lu;
    assign perf_flush_cnt = r_perf_flush;
    assign perf_wait_cnt  = r_perf_wait;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl.
// DUT built with WAIT_TIMEOUT=4 so the timeout path is reachable quickly.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, branch_taken;
    logic       dmem_req, dmem_ready;
    logic       stall, ifid_hold, ifid_flush, idex_hold, idex_flush;
    logic       exmem_hold, memwb_flush, bus_err;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .stall        (stall),
        .ifid_hold    (ifid_hold),
        .ifid_flush   (ifid_flush),
        .idex_hold    (idex_hold),
        .idex_flush   (idex_flush),
        .exmem_hold   (exmem_hold),
        .memwb_flush  (memwb_flush),
        .bus_err      (bus_err),
`ifdef HAZARD_PERF_EN
        .perf_lu_cnt    (perf_lu_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_wait_cnt  (perf_wait_cnt),
`endif
        .state_o      (state_o)
    );

    // {stall, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush}
    logic [6:0] w_out;
    assign w_out = {stall, ifid_hold, ifid_flush, idex_hold, idex_flush,
                    exmem_hold, memwb_flush};

    localparam logic [6:0] O_RUN = 7'b1000000;
    localparam logic [6:0] O_LU  = 7'b0100100;
    localparam logic [6:0] O_MP  = 7'b1010100;
    localparam logic [6:0] O_FRZ = 7'b0101011;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sample the current cycle on negedge, then advance to just after posedge.
    task automatic probe(input string tag, input logic [6:0] eo, input logic [1:0] es,
                         input logic eb);
        @(negedge clk);
        check({tag, "_out"}, 32'(w_out), 32'(eo));
        check({tag, "_st"},  32'(state_o), 32'(es));
        check({tag, "_be"},  32'(bus_err), 32'(eb));
        @(posedge clk); #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        // Reset forces run outputs even with every hazard source active.
        dmem_req = 1'b1; branch_taken = 1'b1;
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        probe("rst", O_RUN, 2'd0, 1'b0);
        reset = 1'b0; idle();
        probe("idle", O_RUN, 2'd0, 1'b0);

        // Load-use on rs1, then cleared.
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        probe("lu_rs1", O_LU, 2'd0, 1'b0);
        ex_is_load = 1'b0;
        probe("lu_next", O_RUN, 2'd0, 1'b0);
        // Load to x0 never stalls.
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        probe("lu_x0", O_RUN, 2'd0, 1'b0);
        // Load-use on rs2; then same indices but rs2 not read.
        id_use_rs1 = 1'b0; id_rs1 = 5'd1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        probe("lu_rs2", O_LU, 2'd0, 1'b0);
        id_use_rs2 = 1'b0;
        probe("lu_nouse", O_RUN, 2'd0, 1'b0);

        // Mispredict overrides a simultaneous load-use.
        ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; branch_taken = 1'b1;
        probe("mp_lu", O_MP, 2'd0, 1'b0);
        idle();
        probe("mp_next", O_RUN, 2'd0, 1'b0);

        // Zero-wait access.
        dmem_req = 1'b1; dmem_ready = 1'b1;
        probe("zw", O_RUN, 2'd0, 1'b0);
        idle();
        probe("zw_next", O_RUN, 2'd0, 1'b0);

        // Ready low for 3 cycles, then high.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        probe("w_entry", O_FRZ, 2'd0, 1'b0);
        probe("w_1", O_FRZ, 2'd1, 1'b0);
        probe("w_2", O_FRZ, 2'd1, 1'b0);
        dmem_ready = 1'b1;
        probe("w_rel", O_RUN, 2'd1, 1'b0);
        idle();
        probe("w_back", O_RUN, 2'd0, 1'b0);

        // Freeze masks branch_taken; flush fires in the release cycle.
        dmem_req = 1'b1; branch_taken = 1'b1;
        probe("fb_entry", O_FRZ, 2'd0, 1'b0);
        probe("fb_wait", O_FRZ, 2'd1, 1'b0);
        dmem_ready = 1'b1;
        probe("fb_rel", O_MP, 2'd1, 1'b0);
        idle();
        probe("fb_back", O_RUN, 2'd0, 1'b0);

        // Timeout: entry + 4 wait cycles, then ERR.
        dmem_req = 1'b1;
        probe("to_entry", O_FRZ, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) probe("to_wait", O_FRZ, 2'd1, 1'b0);
        dmem_req = 1'b0; dmem_ready = 1'b1; branch_taken = 1'b1;
        probe("err_a", O_FRZ, 2'd2, 1'b1);
        probe("err_b", O_FRZ, 2'd2, 1'b1);
        reset = 1'b1;
        probe("err_rst", O_RUN, 2'd2, 1'b1);
        reset = 1'b0; idle();
        probe("err_clr", O_RUN, 2'd0, 1'b0);

        // Reset in the middle of a wait.
        dmem_req = 1'b1;
        probe("mr_entry", O_FRZ, 2'd0, 1'b0);
        probe("mr_wait", O_FRZ, 2'd1, 1'b0);
        reset = 1'b1;
        probe("mr_rst", O_RUN, 2'd1, 1'b0);
        reset = 1'b0; idle();
        probe("mr_after", O_RUN, 2'd0, 1'b0);

`ifdef HAZARD_PERF_EN
        reset = 1'b1;
        probe("pf_rst", O_RUN, 2'd0, 1'b0);
        reset = 1'b0;
        ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        probe("pf_lu1", O_LU, 2'd0, 1'b0);
        probe("pf_lu2", O_LU, 2'd0, 1'b0);
        idle(); branch_taken = 1'b1;
        probe("pf_mp", O_MP, 2'd0, 1'b0);
        idle(); dmem_req = 1'b1;
        probe("pf_w0", O_FRZ, 2'd0, 1'b0);
        probe("pf_w1", O_FRZ, 2'd1, 1'b0);
        probe("pf_w2", O_FRZ, 2'd1, 1'b0);
        dmem_ready = 1'b1;
        probe("pf_rel", O_RUN, 2'd1, 1'b0);
        idle();
        @(negedge clk);
        check("perf_lu", perf_lu_cnt, 32'd2);
        check("perf_flush", perf_flush_cnt, 32'd1);
        check("perf_wait", perf_wait_cnt, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
